bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waiting on any TReady edge before abort.
REQ-002 Parameter ADDR_W, default 16: Address_Bus and address/count register width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse launching a copy; sampled only in IDLE.
REQ-006 src_addr, dst_addr, count  input  16 each  copy source, destination, byte count; latched on accepted start.
REQ-007 bus_req  output  1  request for bus ownership.
REQ-008 bus_grant  input  1  arbiter grant.
REQ-009 Address_Bus  inout  16  driven only while owning the bus, else high-Z.
REQ-010 Data_Bus  inout  8  driven only in write states, else high-Z.
REQ-011 Control  inout  1  1=write, 0=read; driven only while owning the bus, else high-Z.
REQ-012 IReady  inout  1  initiator strobe; driven while owning the bus, else high-Z.
REQ-013 TReady  input  1  target acknowledge.
REQ-014 busy, done, error  output  1 each  transfer active / one-cycle completion pulse / sticky abort flag.

Function
REQ-015 States: IDLE, GRANT_WAIT, RD_SETUP, RD_REQ, RD_REL, WR_SETUP, WR_REQ, WR_REL, NEXT, FINISH, ABORT.
REQ-016 IDLE + start, count!=0: latch inputs, clear error, go GRANT_WAIT, busy=1, bus_req=1 from next cycle.
REQ-017 IDLE + start, count==0: done pulses one cycle later; no bus_req, error cleared, bus untouched.
REQ-018 start outside IDLE shall be ignored.
REQ-019 GRANT_WAIT -> RD_SETUP when bus_grant=1.
REQ-020 RD_SETUP: Address_Bus=src, Control=0, IReady=0, one cycle; then RD_REQ raises IReady=1 (address stable >=1 cycle before IReady rises).
REQ-021 RD_REQ: on sampled TReady=1 capture Data_Bus into data register, go RD_REL with IReady=0.
REQ-022 RD_REL: on sampled TReady=0 go WR_SETUP.
REQ-023 WR_SETUP: Address_Bus=dst, Control=1, Data_Bus=captured byte, IReady=0, one cycle; WR_REQ raises IReady=1.
REQ-024 WR_REQ: on TReady=1 go WR_REL with IReady=0; WR_REL: on TReady=0 go NEXT.
REQ-025 NEXT: src+=1, dst+=1 (modulo 2^16, 0xFFFF wraps to 0x0000), remaining-=1; remaining==0 -> FINISH, else RD_SETUP keeping bus.
REQ-026 FINISH: done=1 one cycle, bus_req=0, bus released to high-Z, busy=0, -> IDLE.
REQ-027 Timeout counter clears on every state entry; counts in RD_REQ, RD_REL, WR_REQ, WR_REL; reaching TIMEOUT -> ABORT.
REQ-028 ABORT: IReady=0, bus released, bus_req=0, error=1 (sticky until next accepted start), done=1 one cycle, -> IDLE.
REQ-029 bus_grant=0 in RD_SETUP/WR_SETUP returns to GRANT_WAIT (address/count preserved, bus released); grant ignored in REQ/REL states.
REQ-030 Data_Bus never driven while Control=0; IReady never rises without valid address/Control from the previous cycle.

Reset
REQ-031 reset asserts immediately: state IDLE, bus_req=0, busy=0, done=0, error=0, all bus outputs high-Z, counters/registers zero.
REQ-032 Reset mid-handshake shall abandon the transaction without completing the TReady release.

Structure
REQ-033 Package dma_pkg holds state enum, CTRL_READ=0/CTRL_WRITE=1, default TIMEOUT.
REQ-034 One sub-module handshake_timer (clear, enable, expired) implements REQ-027.

Verification (target RAM slave at 16..599, Memory[a-16]=a-16 initially)
REQ-035 start src=20 dst=100 count=3 -> addresses 100..102 read back 4,5,6; 6 IReady pulses; single done; error=0.
REQ-036 start count=0 -> done one cycle later, bus_req never asserts, bus stays high-Z.
REQ-037 start src=5 (unmapped) -> TReady never rises; ABORT after TIMEOUT cycles in RD_REQ; error=1, done=1, IReady=0, bus high-Z.
REQ-038 bus_grant held low 10 cycles after start -> no bus driven; copy completes normally once granted.
REQ-039 reset asserted in WR_REQ of second byte -> outputs idle same cycle; first byte written, second not.
REQ-040 start pulsed while busy with different args -> ignored; original copy completes unchanged.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared encodings for the bus_initiator copy engine: FSM state codes,
// Control-line values and the default handshake timeout.
package dma_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE       = 4'd0;
  localparam state_t ST_GRANT_WAIT = 4'd1;
  localparam state_t ST_RD_SETUP   = 4'd2;
  localparam state_t ST_RD_REQ     = 4'd3;
  localparam state_t ST_RD_REL     = 4'd4;
  localparam state_t ST_WR_SETUP   = 4'd5;
  localparam state_t ST_WR_REQ     = 4'd6;
  localparam state_t ST_WR_REL     = 4'd7;
  localparam state_t ST_NEXT       = 4'd8;
  localparam state_t ST_FINISH     = 4'd9;
  localparam state_t ST_ABORT      = 4'd10;

  localparam logic CTRL_READ  = 1'b0;
  localparam logic CTRL_WRITE = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

  // States in which the initiator owns and drives the shared bus.
  function automatic logic owns_bus(input state_t s);
    return s inside {ST_RD_SETUP, ST_RD_REQ, ST_RD_REL,
                     ST_WR_SETUP, ST_WR_REQ, ST_WR_REL, ST_NEXT};
  endfunction

  function automatic logic in_write_phase(input state_t s);
    return s inside {ST_WR_SETUP, ST_WR_REQ, ST_WR_REL};
  endfunction

  // States that wait on a TReady edge and are therefore time-limited.
  function automatic logic in_handshake(input state_t s);
    return s inside {ST_RD_REQ, ST_RD_REL, ST_WR_REQ, ST_WR_REL};
  endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Command and arbitration signals between the copy engine and its system:
// job launch/status, bus request/grant and the target acknowledge.
interface bus_initiator_if #(
  parameter int ADDR_W = 16
) ();

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] count;
  logic              busy;
  logic              done;
  logic              error;
  logic              bus_req;
  logic              bus_grant;
  logic              TReady;

  modport master (
    input  start, src_addr, dst_addr, count, bus_grant, TReady,
    output busy, done, error, bus_req
  );

  modport slave (
    output start, src_addr, dst_addr, count, bus_grant, TReady,
    input  busy, done, error, bus_req
  );

endinterface

// File: rtl/handshake_timer.sv
// Cycle counter bounding how long the initiator waits on one TReady edge;
// expired is high in the last permitted cycle of a waiting state.
module handshake_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // cnt_q holds the cycles already spent in the current state, so a state
  // is allowed exactly TIMEOUT cycles before expired forces the abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_initiator.sv
// Memory-to-memory byte copy engine: arbitrates for a shared tristate bus and
// moves count bytes from src to dst with a four-phase IReady/TReady handshake.
module bus_initiator
  import dma_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  bus_initiator_if.master   ctl,
  inout  wire  [ADDR_W-1:0] Address_Bus,
  inout  wire  [7:0]        Data_Bus,
  inout  wire               Control,
  inout  wire               IReady
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q, rem_q;
  logic [7:0]        data_q;
  logic              error_q;
  logic              tmr_expired;
  logic              own, wr_phase, strobe;

  handshake_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (in_handshake(state_q)),
    .expired (tmr_expired)
  );

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctl.start) begin
          state_d = (ctl.count != '0) ? ST_GRANT_WAIT : ST_FINISH;
        end
      end
      ST_GRANT_WAIT: begin
        if (ctl.bus_grant) state_d = ST_RD_SETUP;
      end
      // Losing the grant is only honoured before a strobe is raised; once a
      // handshake is under way it is completed (or timed out) first.
      ST_RD_SETUP: state_d = ctl.bus_grant ? ST_RD_REQ : ST_GRANT_WAIT;
      ST_RD_REQ: begin
        if (ctl.TReady)   state_d = ST_RD_REL;
        else if (tmr_expired) state_d = ST_ABORT;
      end
      ST_RD_REL: begin
        if (!ctl.TReady)  state_d = ST_WR_SETUP;
        else if (tmr_expired) state_d = ST_ABORT;
      end
      ST_WR_SETUP: state_d = ctl.bus_grant ? ST_WR_REQ : ST_GRANT_WAIT;
      ST_WR_REQ: begin
        if (ctl.TReady)   state_d = ST_WR_REL;
        else if (tmr_expired) state_d = ST_ABORT;
      end
      ST_WR_REL: begin
        if (!ctl.TReady)  state_d = ST_NEXT;
        else if (tmr_expired) state_d = ST_ABORT;
      end
      ST_NEXT: state_d = (rem_q == ADDR_W'(1)) ? ST_FINISH : ST_RD_SETUP;
      ST_FINISH: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (ctl.start) begin
            error_q <= 1'b0;
            if (ctl.count != '0) begin
              src_q <= ctl.src_addr;
              dst_q <= ctl.dst_addr;
              rem_q <= ctl.count;
            end
          end
        end
        ST_RD_REQ: begin
          if (ctl.TReady) data_q <= Data_Bus;
        end
        ST_NEXT: begin
          src_q <= src_q + ADDR_W'(1);
          dst_q <= dst_q + ADDR_W'(1);
          rem_q <= rem_q - ADDR_W'(1);
        end
        default: ;
      endcase
      if (state_d == ST_ABORT) error_q <= 1'b1;
    end
  end

  // Bus pins are a pure decode of the state register, so an asynchronous
  // reset releases them in the same cycle it is asserted.
  assign own      = owns_bus(state_q);
  assign wr_phase = in_write_phase(state_q);
  assign strobe   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);

  assign Address_Bus = own      ? (wr_phase ? dst_q : src_q)           : {ADDR_W{1'bz}};
  assign Control     = own      ? (wr_phase ? CTRL_WRITE : CTRL_READ)  : 1'bz;
  assign IReady      = own      ? strobe                               : 1'bz;
  assign Data_Bus    = wr_phase ? data_q                               : 8'bz;

  assign ctl.bus_req = (state_q == ST_GRANT_WAIT) || own;
  assign ctl.busy    = !(state_q inside {ST_IDLE, ST_FINISH, ST_ABORT});
  assign ctl.done    = (state_q == ST_FINISH) || (state_q == ST_ABORT);
  assign ctl.error   = error_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: a RAM target at 16..599 with pulled-up
// address/data/control lines, so a released bus reads all ones.
module tb_bus_initiator;

  localparam int TO = 255;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic grant_en = 1'b1;

  int checks = 0;
  int errors = 0;

  wire [15:0] address_bus;
  wire [7:0]  data_bus;
  wire        control;
  wire        iready;

  pullup (address_bus);
  pullup (data_bus);
  pullup (control);
  pulldown (iready);

  bus_initiator_if #(.ADDR_W(16)) bif ();

  bus_initiator #(.TIMEOUT(TO), .ADDR_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctl         (bif),
    .Address_Bus (address_bus),
    .Data_Bus    (data_bus),
    .Control     (control),
    .IReady      (iready)
  );

  always #5 clk = ~clk;

  assign bif.bus_grant = bif.bus_req & grant_en;

  // RAM target: Memory[a-16] starts as a-16, answers any mapped strobe.
  logic [7:0] mem [0:583];
  logic       mem_init = 1'b0;
  logic       mapped;
  logic [9:0] mem_idx;

  assign mapped   = (address_bus >= 16'd16) && (address_bus <= 16'd599);
  assign mem_idx  = 10'(address_bus - 16'd16);
  assign data_bus = (iready === 1'b1 && control === 1'b0 && mapped) ? mem[mem_idx] : 8'bz;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bif.TReady <= 1'b0;
      if (!mem_init) begin
        for (int i = 0; i < 584; i++) mem[i] <= 8'(i);
        mem_init <= 1'b1;
      end
    end else if (iready === 1'b1 && mapped) begin
      if (control === 1'b1 && !bif.TReady) mem[mem_idx] <= data_bus;
      bif.TReady <= 1'b1;
    end else begin
      bif.TReady <= 1'b0;
    end
  end

  // Activity monitors, sampled on the rising edge.
  int   done_cnt = 0, rise_cnt = 0, req_cyc = 0, drive_cyc = 0;
  logic ir_prev = 1'b0;

  always @(posedge clk) begin
    ir_prev <= iready;
    if (iready === 1'b1 && ir_prev !== 1'b1) rise_cnt <= rise_cnt + 1;
    if (bif.done) done_cnt <= done_cnt + 1;
    if (bif.bus_req) req_cyc <= req_cyc + 1;
    if (address_bus !== 16'hFFFF || control !== 1'b1) drive_cyc <= drive_cyc + 1;
  end

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
    @(negedge clk);
    bif.start = 1'b1; bif.src_addr = s; bif.dst_addr = d; bif.count = c;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bif.done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #11;
    checks++; if (bif.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", bif.done); end
    checks++; if (bif.error !== 1'b0)   begin errors++; $display("FAIL reset_error: got %b want 0", bif.error); end
    checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bif.bus_req); end
    checks++; if (address_bus !== 16'hFFFF || control !== 1'b1 || data_bus !== 8'hFF || iready !== 1'b0) begin
      errors++; $display("FAIL reset_bus_hiz: addr %h ctrl %b data %h iready %b want released", address_bus, control, data_bus, iready);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_copy;
    int   d0, r0;
    logic seen;
    d0 = done_cnt; r0 = rise_cnt;
    pulse_start(16'd20, 16'd100, 16'd3);
    checks++; if (bif.busy !== 1'b1 || bif.bus_req !== 1'b1) begin
      errors++; $display("FAIL copy_launch: busy %b bus_req %b want 1 1", bif.busy, bif.bus_req);
    end
    wait_done(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL copy_done_timeout: no done within 100 cycles"); end
    checks++; if (bif.error !== 1'b0 || bif.busy !== 1'b0) begin
      errors++; $display("FAIL copy_status: error %b busy %b want 0 0", bif.error, bif.busy);
    end
    repeat (2) @(negedge clk);
    checks++; if (mem[84] !== 8'd4) begin errors++; $display("FAIL copy_byte0: got %0d want 4", mem[84]); end
    checks++; if (mem[85] !== 8'd5) begin errors++; $display("FAIL copy_byte1: got %0d want 5", mem[85]); end
    checks++; if (mem[86] !== 8'd6) begin errors++; $display("FAIL copy_byte2: got %0d want 6", mem[86]); end
    checks++; if (rise_cnt - r0 !== 6) begin errors++; $display("FAIL copy_iready_pulses: got %0d want 6", rise_cnt - r0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL copy_single_done: got %0d want 1", done_cnt - d0); end
    checks++; if (address_bus !== 16'hFFFF || control !== 1'b1 || bif.bus_req !== 1'b0) begin
      errors++; $display("FAIL copy_release: addr %h ctrl %b bus_req %b want ffff 1 0", address_bus, control, bif.bus_req);
    end
  endtask

  task automatic test_timeout;
    int   ir_cycles;
    logic seen;
    ir_cycles = 0; seen = 1'b0;
    pulse_start(16'd5, 16'd200, 16'd1);
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (iready === 1'b1) ir_cycles++;
      if (bif.done) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_no_abort: no done within 400 cycles"); end
    checks++; if (ir_cycles !== TO) begin errors++; $display("FAIL timeout_rd_req_cycles: got %0d want %0d", ir_cycles, TO); end
    checks++; if (bif.error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", bif.error); end
    checks++; if (iready !== 1'b0 || address_bus !== 16'hFFFF || control !== 1'b1 || bif.bus_req !== 1'b0) begin
      errors++; $display("FAIL timeout_release: iready %b addr %h ctrl %b bus_req %b want 0 ffff 1 0", iready, address_bus, control, bif.bus_req);
    end
    @(negedge clk);
    checks++; if (bif.done !== 1'b0 || bif.error !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: done %b error %b want 0 1", bif.done, bif.error);
    end
  endtask

  task automatic test_zero_count;
    int q0, v0;
    q0 = req_cyc; v0 = drive_cyc;
    pulse_start(16'd0, 16'd0, 16'd0);
    checks++; if (bif.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", bif.done); end
    checks++; if (bif.error !== 1'b0) begin errors++; $display("FAIL zero_error_clear: got %b want 0", bif.error); end
    @(negedge clk);
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", bif.done); end
    @(negedge clk);
    checks++; if (req_cyc - q0 !== 0) begin errors++; $display("FAIL zero_bus_req: got %0d cycles want 0", req_cyc - q0); end
    checks++; if (drive_cyc - v0 !== 0) begin errors++; $display("FAIL zero_bus_driven: got %0d cycles want 0", drive_cyc - v0); end
  endtask

  task automatic test_grant_delay;
    int   v0;
    logic seen;
    grant_en = 1'b0;
    v0 = drive_cyc;
    pulse_start(16'd30, 16'd300, 16'd2);
    repeat (9) @(negedge clk);
    checks++; if (bif.bus_req !== 1'b1 || bif.busy !== 1'b1) begin
      errors++; $display("FAIL grant_wait_req: bus_req %b busy %b want 1 1", bif.bus_req, bif.busy);
    end
    checks++; if (drive_cyc - v0 !== 0) begin errors++; $display("FAIL grant_wait_driven: got %0d cycles want 0", drive_cyc - v0); end
    grant_en = 1'b1;
    wait_done(100, seen);
    checks++; if (!seen || bif.error !== 1'b0) begin errors++; $display("FAIL grant_done: seen %b error %b want 1 0", seen, bif.error); end
    repeat (2) @(negedge clk);
    checks++; if (mem[284] !== 8'd14 || mem[285] !== 8'd15) begin
      errors++; $display("FAIL grant_data: got %0d %0d want 14 15", mem[284], mem[285]);
    end
  endtask

  task automatic test_busy_ignore;
    int   d0;
    logic seen;
    d0 = done_cnt;
    pulse_start(16'd40, 16'd400, 16'd2);
    repeat (3) @(negedge clk);
    pulse_start(16'd60, 16'd500, 16'd4);
    wait_done(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL ignore_done_timeout: no done within 100 cycles"); end
    repeat (4) @(negedge clk);
    checks++; if (mem[384] !== 8'd24 || mem[385] !== 8'd25) begin
      errors++; $display("FAIL ignore_orig_data: got %0d %0d want 24 25", mem[384], mem[385]);
    end
    checks++; if (mem[386] !== 8'd130 || mem[484] !== 8'd228) begin
      errors++; $display("FAIL ignore_untouched: got %0d %0d want 130 228", mem[386], mem[484]);
    end
    checks++; if (done_cnt - d0 !== 1 || bif.busy !== 1'b0) begin
      errors++; $display("FAIL ignore_single_job: done %0d busy %b want 1 0", done_cnt - d0, bif.busy);
    end
  endtask

  task automatic test_reset_mid;
    int   rises;
    logic prev, found;
    rises = 0; found = 1'b0;
    pulse_start(16'd50, 16'd520, 16'd2);
    prev = iready;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (iready === 1'b1 && prev !== 1'b1) rises++;
      prev = iready;
      if (rises == 4) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_reach: got %0d strobes want 4", rises); end
    reset = 1'b1;
    #1;
    checks++; if (bif.busy !== 1'b0 || bif.bus_req !== 1'b0 || bif.done !== 1'b0) begin
      errors++; $display("FAIL midreset_status: busy %b bus_req %b done %b want 0 0 0", bif.busy, bif.bus_req, bif.done);
    end
    checks++; if (iready !== 1'b0 || address_bus !== 16'hFFFF || control !== 1'b1 || data_bus !== 8'hFF) begin
      errors++; $display("FAIL midreset_bus: iready %b addr %h ctrl %b data %h want released", iready, address_bus, control, data_bus);
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem[504] !== 8'd34) begin errors++; $display("FAIL midreset_first_byte: got %0d want 34", mem[504]); end
    checks++; if (mem[505] !== 8'd249) begin errors++; $display("FAIL midreset_second_byte: got %0d want 249", mem[505]); end
  endtask

  initial begin
    bif.start = 1'b0;
    bif.src_addr = '0;
    bif.dst_addr = '0;
    bif.count = '0;
    test_reset();
    test_copy();
    test_timeout();
    test_zero_count();
    test_grant_delay();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
